// File: rtl/la_dffpipe.sv
// ---------------------------------------------------------------------------
// la_dffpipe
//
// Purpose:
//   Elastic register pipeline. WIDTH-bit words travel through DEPTH flop
//   stages, each with its own valid bit and valid/ready handshake. Stages hold
//   under back-pressure and empty stages (bubbles) are filled immediately,
//   because each stage's ready looks at every stage between it and the output.
//   Used for retiming long paths, crossing floorplan regions and buffering
//   stream interfaces within a single clock domain.
//
// Parameters:
//   WIDTH   data width in bits (>=1)
//   DEPTH   number of register stages (>=1)
//   RSTVAL  value loaded into every stage's data register on reset
//   PROP    implementation property string for technology mapping
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset (wins over flush)
//   flush      synchronous discard of all pipeline contents
//   in_valid   upstream has data
//   in_ready   pipeline accepts in_data this cycle
//   in_data    upstream data
//   out_valid  output stage holds valid data
//   out_ready  downstream accepts out_data this cycle
//   out_data   data from the last stage
//   count      number of stages currently holding valid data
// ---------------------------------------------------------------------------
module la_dffpipe #(
   parameter int               WIDTH  = 1,
   parameter int               DEPTH  = 2,
   parameter logic [WIDTH-1:0] RSTVAL = '0,
   parameter string            PROP   = "DEFAULT"
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             out_data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CountW = $clog2(DEPTH+1);

   // PROP only steers technology mapping; it has no effect on the RTL
   // behaviour, so it simply selects an empty block here.
   if (PROP == "") begin : gNoProp
   end

   logic [DEPTH-1:0] r_valid;
   logic [WIDTH-1:0] r_data [DEPTH];

   logic [DEPTH-1:0] w_rdy;
   logic             w_tailFull;
   logic [DEPTH-1:0] w_inValid;
   logic [WIDTH-1:0] w_inData [DEPTH];
   logic [CountW-1:0] w_count;

   // Stage readiness. A stage can load when it is empty or the stage after it
   // can load; unrolled, that is "downstream is ready or some stage from here
   // to the output is empty". Computing it that way from a running AND of the
   // tail valids avoids a self-referencing vector while keeping the same
   // out_ready -> in_ready chain.
   always_comb begin
      w_rdy      = '0;
      w_tailFull = 1'b1;
      for (int i = DEPTH-1; i >= 0; i--) begin
         w_tailFull = w_tailFull & r_valid[i];
         w_rdy[i]   = out_ready | ~w_tailFull;
      end
   end

   // What each stage would load: stage 0 takes the upstream interface, every
   // other stage takes the contents of the stage before it.
   always_comb begin
      w_inValid    = '0;
      w_inValid[0] = in_valid;
      w_inData[0]  = in_data;
      for (int i = 1; i < DEPTH; i++) begin
         w_inValid[i] = r_valid[i-1];
         w_inData[i]  = r_data[i-1];
      end
   end

   // Stage registers. Reset clears valids and presets data; flush only clears
   // valids. Otherwise a ready stage takes its incoming valid, but its data
   // register only toggles when that incoming word is actually valid, so a
   // drained pipe keeps showing the last word that passed through.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_data[i] <= RSTVAL;
         end
      end else if (flush) begin
         r_valid <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_rdy[i]) begin
               r_valid[i] <= w_inValid[i];
               if (w_inValid[i]) begin
                  r_data[i] <= w_inData[i];
               end
            end
         end
      end
   end

   // Occupancy is just the number of set valid bits.
   always_comb begin
      w_count = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_count = w_count + CountW'(r_valid[i]);
      end
   end

   // During a flush cycle both handshakes are blocked so that nothing is
   // accepted or emitted while the contents are being discarded.
   assign in_ready  = w_rdy[0] & ~flush;
   assign out_valid = r_valid[DEPTH-1] & ~flush;
   assign out_data  = r_data[DEPTH-1];
   assign count     = w_count;

endmodule

// File: tb/tb_la_dffpipe.sv
// ---------------------------------------------------------------------------
// tb_la_dffpipe
//
// Directed bench for la_dffpipe with WIDTH=8, DEPTH=3, RSTVAL=8'hA5: reset
// state, latency and streaming, back-pressure fill and drain, bubble
// collapse, mid-stream reset, flush, then a random phase checked against a
// queue of accepted-but-not-emitted words.
// ---------------------------------------------------------------------------
module tb_la_dffpipe;

   localparam int         Width  = 8;
   localparam int         Depth  = 3;
   localparam logic [7:0] RstVal = 8'hA5;

   logic             clk = 1'b0;
   logic             reset;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [Width-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [Width-1:0] out_data;
   logic [1:0]       count;

   int asserts  = 0;
   int failures = 0;

   logic [7:0] q [$];
   logic       prevHold;
   logic [7:0] prevData;
   logic       rIv;
   logic       rOrdy;
   logic       rFl;
   logic [7:0] rD;
   logic       expValid;
   logic [7:0] expData;
   int         expCount;

   // Free-running clock; rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   la_dffpipe #(
      .WIDTH  (Width),
      .DEPTH  (Depth),
      .RSTVAL (RstVal),
      .PROP   ("DEFAULT")
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
   );

   // One cycle of stimulus: drive on the falling edge, then let the
   // combinational outputs settle before anything is sampled.
   task automatic applyStimulus(input logic rst, input logic fl, input logic iv,
                                input logic [7:0] d, input logic ordy);
      @(negedge clk);
      reset     = rst;
      flush     = fl;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      #1;
   endtask

   // One comparison, counted, with a failure line on mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      asserts++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Directed sequence followed by the random phase.
   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);

      // Reset state, first cycle with reset and flush low.
      applyStimulus(0, 0, 0, 8'h00, 0);
      checkOutput("reset out_valid", out_valid, 0);
      checkOutput("reset out_data", out_data, 8'hA5);
      checkOutput("reset count", count, 0);
      checkOutput("reset in_ready", in_ready, 1);

      // Streaming 0x01..0x10 with out_ready=1. Word k+1 enters at the edge
      // after step k and is visible on the output three steps later.
      for (int k = 0; k < 20; k++) begin
         if (k < 16) applyStimulus(0, 0, 1, 8'(k + 1), 1);
         else        applyStimulus(0, 0, 0, 8'h00, 1);
         expValid = (k >= 3 && k <= 18);
         expData  = (k < 3) ? 8'hA5 : ((k <= 18) ? 8'(k - 2) : 8'h10);
         expCount = (k < 16) ? ((k < 3) ? k : 3) : (3 - (k - 16));
         checkOutput($sformatf("stream in_ready k=%0d", k), in_ready, 1);
         checkOutput($sformatf("stream out_valid k=%0d", k), out_valid, expValid);
         checkOutput($sformatf("stream out_data k=%0d", k), out_data, expData);
         checkOutput($sformatf("stream count k=%0d", k), count, expCount);
      end

      // Traffic in flight, then a one-cycle reset discards it.
      applyStimulus(0, 0, 1, 8'h61, 0);
      applyStimulus(0, 0, 1, 8'h62, 0);
      checkOutput("pre-reset count", count, 1);
      applyStimulus(1, 0, 1, 8'h63, 0);
      applyStimulus(0, 0, 0, 8'h00, 0);
      checkOutput("midreset out_valid", out_valid, 0);
      checkOutput("midreset out_data", out_data, 8'hA5);
      checkOutput("midreset count", count, 0);
      checkOutput("midreset in_ready", in_ready, 1);

      // Back-pressure fill: four offered, three accepted, output stable.
      applyStimulus(0, 0, 1, 8'h21, 0);
      applyStimulus(0, 0, 1, 8'h22, 0);
      applyStimulus(0, 0, 1, 8'h23, 0);
      checkOutput("fill count 2", count, 2);
      applyStimulus(0, 0, 1, 8'h24, 0);
      checkOutput("fill count full", count, 3);
      checkOutput("fill in_ready full", in_ready, 0);
      checkOutput("fill out_valid", out_valid, 1);
      checkOutput("fill out_data", out_data, 8'h21);
      applyStimulus(0, 0, 1, 8'h24, 0);
      checkOutput("fill in_ready held", in_ready, 0);
      checkOutput("fill out_data held", out_data, 8'h21);
      checkOutput("fill count held", count, 3);
      // Drain in order.
      applyStimulus(0, 0, 0, 8'h00, 1);
      checkOutput("drain in_ready", in_ready, 1);
      checkOutput("drain word 1", out_data, 8'h21);
      checkOutput("drain count 3", count, 3);
      applyStimulus(0, 0, 0, 8'h00, 1);
      checkOutput("drain word 2", out_data, 8'h22);
      checkOutput("drain count 2", count, 2);
      applyStimulus(0, 0, 0, 8'h00, 1);
      checkOutput("drain word 3", out_data, 8'h23);
      checkOutput("drain valid 3", out_valid, 1);
      applyStimulus(0, 0, 0, 8'h00, 0);
      checkOutput("drain empty valid", out_valid, 0);
      checkOutput("drain empty count", count, 0);
      checkOutput("drain empty data", out_data, 8'h23);

      // Bubble collapse: A, two idle cycles, B, all with out_ready=0.
      applyStimulus(0, 0, 1, 8'h3A, 0);
      applyStimulus(0, 0, 0, 8'h00, 0);
      applyStimulus(0, 0, 0, 8'h00, 0);
      applyStimulus(0, 0, 1, 8'h3B, 0);
      checkOutput("bubble A at output", out_data, 8'h3A);
      checkOutput("bubble count 1", count, 1);
      applyStimulus(0, 0, 0, 8'h00, 0);
      applyStimulus(0, 0, 0, 8'h00, 0);
      checkOutput("bubble count 2", count, 2);
      checkOutput("bubble in_ready", in_ready, 1);
      checkOutput("bubble out_valid", out_valid, 1);
      checkOutput("bubble out_data", out_data, 8'h3A);
      applyStimulus(0, 0, 0, 8'h00, 1);
      checkOutput("bubble emit A", out_data, 8'h3A);
      applyStimulus(0, 0, 0, 8'h00, 1);
      checkOutput("bubble emit B", out_data, 8'h3B);
      checkOutput("bubble emit B valid", out_valid, 1);
      applyStimulus(0, 0, 0, 8'h00, 1);
      checkOutput("bubble drained", count, 0);

      // Flush with three words held and out_ready=1.
      applyStimulus(0, 0, 1, 8'h41, 0);
      applyStimulus(0, 0, 1, 8'h42, 0);
      applyStimulus(0, 0, 1, 8'h43, 0);
      applyStimulus(0, 1, 1, 8'h49, 1);
      checkOutput("flush out_valid", out_valid, 0);
      checkOutput("flush in_ready", in_ready, 0);
      checkOutput("flush count before", count, 3);
      applyStimulus(0, 0, 1, 8'h50, 1);
      checkOutput("postflush count", count, 0);
      checkOutput("postflush out_valid", out_valid, 0);
      checkOutput("postflush in_ready", in_ready, 1);
      applyStimulus(0, 0, 0, 8'h00, 1);
      checkOutput("postflush lat1 valid", out_valid, 0);
      checkOutput("postflush lat1 count", count, 1);
      applyStimulus(0, 0, 0, 8'h00, 1);
      checkOutput("postflush lat2 valid", out_valid, 0);
      applyStimulus(0, 0, 0, 8'h00, 1);
      checkOutput("postflush lat3 valid", out_valid, 1);
      checkOutput("postflush lat3 data", out_data, 8'h50);
      applyStimulus(0, 0, 0, 8'h00, 1);
      checkOutput("postflush empty", count, 0);

      // Random phase against a queue of words accepted but not yet emitted;
      // the last few cycles drain the pipe.
      q.delete();
      prevHold = 1'b0;
      prevData = 8'h00;
      for (int c = 0; c < 406; c++) begin
         if (c < 400) begin
            rIv   = ($urandom_range(0, 9) < 7);
            rOrdy = ($urandom_range(0, 9) < 6);
            rFl   = ($urandom_range(0, 31) == 0);
            rD    = 8'($urandom);
         end else begin
            rIv   = 1'b0;
            rOrdy = 1'b1;
            rFl   = 1'b0;
            rD    = 8'h00;
         end
         applyStimulus(0, rFl, rIv, rD, rOrdy);
         checkOutput($sformatf("rand count c=%0d", c), count, q.size());
         checkOutput($sformatf("rand in_ready c=%0d", c), in_ready,
                     (!rFl && (q.size() < Depth || rOrdy)));
         if (q.size() == 0)
            checkOutput($sformatf("rand out_valid empty c=%0d", c), out_valid, 0);
         else if (out_valid)
            checkOutput($sformatf("rand out_data c=%0d", c), out_data, q[0]);
         if (prevHold)
            checkOutput($sformatf("rand hold c=%0d", c), out_data, prevData);
         prevHold = out_valid && !out_ready;
         prevData = out_data;
         if (rFl) begin
            q.delete();
         end else begin
            if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
            if (in_valid && in_ready) q.push_back(in_data);
         end
      end
      checkOutput("rand final count", count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule
